// File: rtl/ex_stage_alu.sv
// rtl/ex_stage_alu.sv - RV32I execute stage: forwarding, ALU and EX/MEM pipeline register
module ex_stage_alu #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [3:0]        alu_ctrl_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              alu_src_i,
    input  logic [1:0]        fwd_a_i,
    input  logic [1:0]        fwd_b_i,
    input  logic [XLEN-1:0]   mem_wb_data_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              reg_write_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              mem_to_reg_i,
    input  logic              branch_i,
    input  logic              jump_i,
    output logic [XLEN-1:0]   alu_result_o,
    output logic [XLEN-1:0]   store_data_o,
    output logic              zero_o,
    output logic              branch_taken_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              mem_to_reg_o
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;

    logic [XLEN-1:0]   alu_result_q, alu_result_d;
    logic [XLEN-1:0]   store_data_q, store_data_d;
    logic              zero_q, zero_d;
    logic              branch_taken_q, branch_taken_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;

    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   rs2_fwd;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   alu_raw;
    logic              alu_zero;

    // Operand forwarding: EX/MEM source is the registered result, so a stall naturally feeds back the held value
    always_comb begin
        op_a = rs1_data_i;
        unique case (fwd_a_i)
            2'b10:   op_a = alu_result_q;
            2'b01:   op_a = mem_wb_data_i;
            default: op_a = rs1_data_i;
        endcase
        rs2_fwd = rs2_data_i;
        unique case (fwd_b_i)
            2'b10:   rs2_fwd = alu_result_q;
            2'b01:   rs2_fwd = mem_wb_data_i;
            default: rs2_fwd = rs2_data_i;
        endcase
        op_b = alu_src_i ? imm_i : rs2_fwd;
    end

    // ALU proper; undefined codes produce zero
    always_comb begin
        alu_raw = '0;
        case (alu_ctrl_i)
            OP_ADD:  alu_raw = op_a + op_b;
            OP_SUB:  alu_raw = op_a - op_b;
            OP_SLL:  alu_raw = op_a << op_b[SHW-1:0];
            OP_SLT:  alu_raw = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_XOR:  alu_raw = op_a ^ op_b;
            OP_OR:   alu_raw = op_a | op_b;
            OP_AND:  alu_raw = op_a & op_b;
            default: alu_raw = '0;
        endcase
        alu_zero = (alu_raw == '0);
    end

    // Values loaded into EX/MEM when the stage advances normally
    always_comb begin
        alu_result_d   = jump_i ? (pc_i + XLEN'(4)) : alu_raw;
        store_data_d   = rs2_fwd;
        zero_d         = alu_zero;
        branch_taken_d = branch_i & alu_zero;
        rd_d           = rd_i;
        reg_write_d    = reg_write_i;
        mem_read_d     = mem_read_i;
        mem_write_d    = mem_write_i;
        mem_to_reg_d   = mem_to_reg_i;
    end

    // EX/MEM register: reset, then flush (bubble), then stall (hold), then load
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            alu_result_q   <= '0;
            store_data_q   <= '0;
            zero_q         <= 1'b0;
            branch_taken_q <= 1'b0;
            rd_q           <= '0;
            reg_write_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_to_reg_q   <= 1'b0;
        end else if (!stall_i) begin
            alu_result_q   <= alu_result_d;
            store_data_q   <= store_data_d;
            zero_q         <= zero_d;
            branch_taken_q <= branch_taken_d;
            rd_q           <= rd_d;
            reg_write_q    <= reg_write_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            mem_to_reg_q   <= mem_to_reg_d;
        end
    end

    assign alu_result_o   = alu_result_q;
    assign store_data_o   = store_data_q;
    assign zero_o         = zero_q;
    assign branch_taken_o = branch_taken_q;
    assign rd_o           = rd_q;
    assign reg_write_o    = reg_write_q;
    assign mem_read_o     = mem_read_q;
    assign mem_write_o    = mem_write_q;
    assign mem_to_reg_o   = mem_to_reg_q;

endmodule

// File: doc/ex_stage_alu.md
Name: ex_stage_alu

Overview:
- Execute stage of the pipelined RV32I core. It consumes the 4-bit ALU control code from the ALU control decoder, plus the operands and control from the ID/EX boundary.
- It performs operand forwarding, operand-B selection and the ALU operation, then captures everything in the EX/MEM pipeline register.
- Single-cycle compute; the registered result is visible one cycle after issue.
- Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register-address width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- stall_i  in  1  hold EX/MEM contents
- flush_i  in  1  load a bubble into EX/MEM
- alu_ctrl_i  in  4  operation code from ALU control
- rs1_data_i  in  XLEN  ID/EX rs1 value
- rs2_data_i  in  XLEN  ID/EX rs2 value
- imm_i  in  XLEN  sign-extended immediate
- pc_i  in  XLEN  instruction PC
- alu_src_i  in  1  1 = operand B is imm_i
- fwd_a_i  in  2  operand A source: 00 regfile, 10 EX/MEM result, 01 MEM/WB data, 11 treated as 00
- fwd_b_i  in  2  operand B source, same encoding as fwd_a_i
- mem_wb_data_i  in  XLEN  MEM/WB write-back value for forwarding
- rd_i  in  REG_AW  destination register
- reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i, branch_i, jump_i  in  1 each  control flags
- alu_result_o  out  XLEN  registered ALU result, or link value for jumps
- store_data_o  out  XLEN  registered forwarded rs2 value
- zero_o  out  1  registered: ALU result == 0
- branch_taken_o  out  1  registered: branch_i & zero
- rd_o  out  REG_AW  registered destination register
- reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o  out  1 each  registered control flags

Behaviour:
- Operand A: the fwd_a_i mux output.
- Operand B:
  - First pass rs2_data_i through the fwd_b_i mux; that forwarded rs2 is what goes to store_data.
  - If alu_src_i = 1, operand B is imm_i; otherwise it is the forwarded rs2.
- EX/MEM forwarding source is the current alu_result_o register (previous instruction's result).
- ALU operations by alu_ctrl_i:
  - 0010 add: A+B, wrap modulo 2^XLEN.
  - 0011 sub: A-B, wraps.
  - 0110 sll: A << B[4:0].
  - 0100 slt: signed compare, result {31'b0, A<B}.
  - 0101 xor, 0001 or, 0111 and: bitwise.
  - 0000 and any undefined code: result 0.
- zero is computed from the raw ALU result.
- jump_i = 1: result field loads pc_i + 4 (link value) instead of the ALU result. zero_o still reflects the raw ALU result.
- Latency: inputs sampled at edge N appear on the outputs after edge N; no combinational paths from inputs to outputs.
- Register update priority, per edge:
  - rst_i: all outputs to 0.
  - else flush_i: all control outputs (reg_write, mem_read, mem_write, mem_to_reg, branch_taken) to 0 and rd_o to 0. Data outputs are don't-care; they are cleared to 0.
  - else stall_i: every output register holds its value.
  - else: load the new values.
- flush_i and stall_i both high: flush wins.
- Reset asserted mid-stream: the next edge clears everything regardless of stall/flush. The first instruction after reset deassertion loads normally.
- A bubble must never produce reg_write_o, mem_write_o or branch_taken_o = 1.
- Forwarding sources are used as presented. The EX/MEM feedback uses the held value while stalled.

Test Plan:
- Reset: hold rst_i with stall_i = 1 and random inputs -> all outputs 0 after the edge.
- Add/sub wrap: alu_ctrl 0010, A = 0xFFFFFFFF, B = 1 -> result 0, zero_o = 1. Then 0011 with A = 0, B = 1 -> 0xFFFFFFFF, zero_o = 0.
- slt/sll/logic:
  - slt with A = 0xFFFFFFFE (-2), B = 3 -> result 1.
  - sll with A = 1, B = 0x25 -> 0x20.
  - and/or/xor with A = 0xF0F0, B = 0x0FF0 -> 0x00F0 / 0xFFF0 / 0xFF00.
  - Code 1111 -> result 0.
- Forwarding:
  - Issue add x1 = 5 + 7 (result 12), then next cycle fwd_a = 10, B = imm 3, add -> result 15.
  - With fwd_b = 01, mem_wb_data = 9, alu_src = 0 -> store_data_o = 9.
- Branch/jump:
  - beq code 0011 with A = B = 0x40 and branch_i = 1 -> branch_taken_o = 1.
  - jump_i = 1, pc_i = 0x100 -> alu_result_o = 0x104.
- Stall/flush:
  - stall_i for 3 cycles -> outputs frozen.
  - flush_i and stall_i together with reg_write_i = mem_write_i = 1 -> reg_write_o = mem_write_o = 0, rd_o = 0.
